// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;

  localparam int          INST_BYTES = 4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// In-order queue of fetched {pc, inst} entries; flush wins over push/pop,
// and a push into a full queue is accepted when a pop happens the same cycle.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int QDEPTH = 4,
  localparam int PTR_W  = $clog2(QDEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     push_data,
  output fetch_entry_t     head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;
  logic             push_ok;
  logic             wr_en;

  assign full    = (count_q == CNT_W'(QDEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign wr_en   = push_ok & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the consumer masks the head while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: owns the fetch PC, drives the same-cycle ROM, queues
// {pc, inst} and hands entries to decode over valid/ready; redirects flush.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             push;
  logic             pop;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count_unused;
  fetch_entry_t     new_entry;
  fetch_entry_t     head_entry;

  assign imem_pc   = fetch_pc_q;
  assign out_valid = ~q_empty;
  assign pop       = out_valid & out_ready & ~redirect_valid;
  assign push      = fetch_en & ~redirect_valid & (~q_full | pop);
  assign new_entry = {fetch_pc_q, imem_inst};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    else if (push)
      fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_pc_q <= RESET_PC;
    else     fetch_pc_q <= fetch_pc_d;
  end

  ifetch_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data (new_entry),
    .head_data (head_entry),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count_unused)
  );

  // Head is forced to zero while empty so stale/uninitialised storage never leaks.
  assign out_pc   = out_valid ? head_entry.pc   : 32'h0;
  assign out_inst = out_valid ? head_entry.inst : 32'h0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: two instances (RESET_PC 0 and 0xFFFF_FFF8) share
// stimulus and are checked against a queue-based reference model.
module tb_ifetch_unit;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'hFFFF_FFF8;
  localparam int          QD    = 4;

  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc_a, imem_inst_a, out_pc_a, out_inst_a;
  logic [31:0] imem_pc_b, imem_inst_b, out_pc_b, out_inst_b;
  logic        out_valid_a, out_valid_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] mpc_a, mpc_b;
  logic [63:0] qa[$];
  logic [63:0] qb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_inst_a = rom(imem_pc_a);
  assign imem_inst_b = rom(imem_pc_b);

  ifetch_unit #(.RESET_PC(RST_A), .QDEPTH(QD)) dut_a (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_pc(imem_pc_a), .imem_inst(imem_inst_a),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(out_pc_a), .out_inst(out_inst_a)
  );

  ifetch_unit #(.RESET_PC(RST_B), .QDEPTH(QD)) dut_b (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_pc(imem_pc_b), .imem_inst(imem_inst_b),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(out_pc_b), .out_inst(out_inst_b)
  );

  logic [96:0] act_a, act_b;
  assign act_a = {out_valid_a, out_pc_a, out_inst_a, imem_pc_a};
  assign act_b = {out_valid_b, out_pc_b, out_inst_b, imem_pc_b};

  // Reference model: advance both fetch streams by one clock edge.
  task automatic model_edge();
    bit pop_ok, push_ok;
    if (rst) begin
      mpc_a = RST_A; qa.delete();
      mpc_b = RST_B; qb.delete();
    end else if (redirect_valid) begin
      mpc_a = {redirect_pc[31:2], 2'b00}; qa.delete();
      mpc_b = {redirect_pc[31:2], 2'b00}; qb.delete();
    end else begin
      pop_ok  = (qa.size() > 0) && out_ready;
      push_ok = fetch_en && ((qa.size() < QD) || pop_ok);
      if (pop_ok) void'(qa.pop_front());
      if (push_ok) begin qa.push_back({mpc_a, rom(mpc_a)}); mpc_a = mpc_a + 32'd4; end
      pop_ok  = (qb.size() > 0) && out_ready;
      push_ok = fetch_en && ((qb.size() < QD) || pop_ok);
      if (pop_ok) void'(qb.pop_front());
      if (push_ok) begin qb.push_back({mpc_b, rom(mpc_b)}); mpc_b = mpc_b + 32'd4; end
    end
  endtask

  function automatic logic [96:0] exp_a();
    return (qa.size() > 0) ? {1'b1, qa[0], mpc_a} : {1'b0, 64'h0, mpc_a};
  endfunction

  function automatic logic [96:0] exp_b();
    return (qb.size() > 0) ? {1'b1, qb[0], mpc_b} : {1'b0, 64'h0, mpc_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    checks++;
    if (act_a !== {1'b0, 64'h0, RST_A}) begin
      errors++; $display("FAIL reset_a: got %h expected %h", act_a, {1'b0, 64'h0, RST_A});
    end
    checks++;
    if (act_b !== {1'b0, 64'h0, RST_B}) begin
      errors++; $display("FAIL reset_b: got %h expected %h", act_b, {1'b0, 64'h0, RST_B});
    end
  endtask

  task automatic test_stream();
    logic [96:0] e;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      e = {1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k), 32'(4 * k + 4)};
      checks++;
      if (act_a !== e) begin
        errors++; $display("FAIL stream[%0d]: got %h expected %h", k, act_a, e);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [96:0] e;
    rst = 1'b1; tick();
    rst = 1'b0; out_ready = 1'b0; fetch_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (act_a !== exp_a()) begin
        errors++; $display("FAIL stall[%0d]: got %h expected %h", k, act_a, exp_a());
      end
    end
    e = {1'b1, 32'h0, 32'h1000_0000, 32'h10};
    checks++;
    if (act_a !== e) begin
      errors++; $display("FAIL stall_hold: got %h expected %h", act_a, e);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      e = {1'b1, 32'(4 * k + 4), 32'h1000_0001 + 32'(k), 32'h10 + 32'(4 * k + 4)};
      checks++;
      if (act_a !== e) begin
        errors++; $display("FAIL drain[%0d]: got %h expected %h", k, act_a, e);
      end
    end
  endtask

  task automatic test_redirect();
    logic [96:0] e;
    rst = 1'b1; tick();
    rst = 1'b0; out_ready = 1'b0; fetch_en = 1'b1;
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    e = {1'b0, 64'h0, 32'h100};
    checks++;
    if (act_a !== e) begin
      errors++; $display("FAIL redir_flush: got %h expected %h", act_a, e);
    end
    redirect_valid = 1'b0;
    tick();
    e = {1'b1, 32'h100, 32'h1000_0040, 32'h104};
    checks++;
    if (act_a !== e) begin
      errors++; $display("FAIL redir_first: got %h expected %h", act_a, e);
    end
  endtask

  task automatic test_redirect_align();
    logic [96:0] e;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    e = {1'b0, 64'h0, 32'h100};
    checks++;
    if (act_a !== e) begin
      errors++; $display("FAIL align_flush: got %h expected %h", act_a, e);
    end
    redirect_valid = 1'b0;
    tick();
    e = {1'b1, 32'h100, 32'h1000_0040, 32'h104};
    checks++;
    if (act_a !== e) begin
      errors++; $display("FAIL align_first: got %h expected %h", act_a, e);
    end
    tick();
    e = {1'b1, 32'h104, 32'h1000_0041, 32'h108};
    checks++;
    if (act_a !== e) begin
      errors++; $display("FAIL align_second: got %h expected %h", act_a, e);
    end
  endtask

  task automatic test_wrap();
    logic [96:0] e;
    logic [31:0] pc;
    rst = 1'b1; tick();
    rst = 1'b0; out_ready = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      pc = RST_B + 32'(4 * k);
      e  = {1'b1, pc, rom(pc), pc + 32'd4};
      checks++;
      if (act_b !== e) begin
        errors++; $display("FAIL wrap[%0d]: got %h expected %h", k, act_b, e);
      end
    end
    fetch_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (imem_pc_b !== 32'h8 || act_b !== exp_b()) begin
        errors++; $display("FAIL freeze[%0d]: got %h expected %h", k, act_b, exp_b());
      end
    end
    checks++;
    if (out_valid_b !== 1'b0) begin
      errors++; $display("FAIL freeze_drained: got %b expected 0", out_valid_b);
    end
    fetch_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      pc = 32'h8 + 32'(4 * k);
      e  = {1'b1, pc, rom(pc), pc + 32'd4};
      checks++;
      if (act_b !== e) begin
        errors++; $display("FAIL resume[%0d]: got %h expected %h", k, act_b, e);
      end
    end
  endtask

  task automatic test_reset_full();
    logic [96:0] e;
    out_ready = 1'b0; fetch_en = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (act_a !== exp_a() || qa.size() != QD) begin
      errors++; $display("FAIL fill: got %h expected %h", act_a, exp_a());
    end
    rst = 1'b1;
    tick();
    e = {1'b0, 64'h0, RST_A};
    checks++;
    if (act_a !== e) begin
      errors++; $display("FAIL reset_full: got %h expected %h", act_a, e);
    end
    rst = 1'b0; out_ready = 1'b1;
    tick();
    e = {1'b1, 32'h0, 32'h1000_0000, 32'h4};
    checks++;
    if (act_a !== e) begin
      errors++; $display("FAIL restart0: got %h expected %h", act_a, e);
    end
    tick();
    e = {1'b1, 32'h4, 32'h1000_0001, 32'h8};
    checks++;
    if (act_a !== e) begin
      errors++; $display("FAIL restart1: got %h expected %h", act_a, e);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst            = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      fetch_en       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (act_a !== exp_a()) begin
        errors++; $display("FAIL rand_a[%0d]: got %h expected %h", k, act_a, exp_a());
      end
      checks++;
      if (act_b !== exp_b()) begin
        errors++; $display("FAIL rand_b[%0d]: got %h expected %h", k, act_b, exp_b());
      end
    end
    rst = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_align();
    test_wrap();
    test_reset_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
